// File: rtl/adam_jtag_tap_pkg.sv
// Shared TAP definitions: controller state encoding, IR opcodes and the
// TMS-driven next-state function.
package adam_jtag_tap_pkg;

  // Encodings follow the customary 1149.1 state numbering.
  typedef enum logic [3:0] {
    TestLogicReset = 4'hF,
    RunTestIdle    = 4'hC,
    SelectDrScan   = 4'h7,
    CaptureDr      = 4'h6,
    ShiftDr        = 4'h2,
    Exit1Dr        = 4'h1,
    PauseDr        = 4'h3,
    Exit2Dr        = 4'h0,
    UpdateDr       = 4'h5,
    SelectIrScan   = 4'h4,
    CaptureIr      = 4'hE,
    ShiftIr        = 4'hA,
    Exit1Ir        = 4'h9,
    PauseIr        = 4'hB,
    Exit2Ir        = 4'h8,
    UpdateIr       = 4'hD
  } tap_state_e;

  localparam logic [4:0] IrIdcode = 5'h01;
  localparam logic [4:0] IrUser   = 5'h10;
  localparam logic [4:0] IrBypass = 5'h1F;

  function automatic tap_state_e tap_next(input tap_state_e state, input logic tms);
    case (state)
      TestLogicReset: tap_next = tms ? TestLogicReset : RunTestIdle;
      RunTestIdle:    tap_next = tms ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   tap_next = tms ? SelectIrScan   : CaptureDr;
      CaptureDr:      tap_next = tms ? Exit1Dr        : ShiftDr;
      ShiftDr:        tap_next = tms ? Exit1Dr        : ShiftDr;
      Exit1Dr:        tap_next = tms ? UpdateDr       : PauseDr;
      PauseDr:        tap_next = tms ? Exit2Dr        : PauseDr;
      Exit2Dr:        tap_next = tms ? UpdateDr       : ShiftDr;
      UpdateDr:       tap_next = tms ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   tap_next = tms ? TestLogicReset : CaptureIr;
      CaptureIr:      tap_next = tms ? Exit1Ir        : ShiftIr;
      ShiftIr:        tap_next = tms ? Exit1Ir        : ShiftIr;
      Exit1Ir:        tap_next = tms ? UpdateIr       : PauseIr;
      PauseIr:        tap_next = tms ? Exit2Ir        : PauseIr;
      Exit2Ir:        tap_next = tms ? UpdateIr       : ShiftIr;
      UpdateIr:       tap_next = tms ? SelectDrScan   : RunTestIdle;
      default:        tap_next = TestLogicReset;
    endcase
  endfunction

endpackage

// File: rtl/adam_jtag_sync.sv
// N-flop synchronizer with a configurable idle/reset value, used once per
// asynchronous JTAG pin.
module adam_jtag_sync #(
  parameter int unsigned Stages     = 2,
  parameter logic        ResetValue = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [Stages-1:0] stages_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages_q <= {Stages{ResetValue}};
    end else begin
      stages_q[0] <= d;
      for (int i = 1; i < Stages; i++) begin
        stages_q[i] <= stages_q[i-1];
      end
    end
  end

  assign q = stages_q[Stages-1];

endmodule

// File: rtl/adam_jtag_tap.sv
// JTAG TAP controller running entirely in the system clock domain; TCK is
// oversampled and its edges act as enables. Supports IDCODE, USER and BYPASS.
module adam_jtag_tap
  import adam_jtag_tap_pkg::*;
#(
  parameter logic [31:0] IDCODE      = 32'h0000_0001,
  parameter int unsigned IR_WIDTH    = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        seq_clk,
  input  logic        seq_rst,
  input  logic        pause_req,
  output logic        pause_ack,
  input  logic        jtag_trst_n,
  input  logic        jtag_tck,
  input  logic        jtag_tms,
  input  logic        jtag_tdi,
  output logic        jtag_tdo,
  output logic [31:0] user_data,
  output logic        user_valid
);

  localparam logic [IR_WIDTH-1:0] IrIdcodeW = IR_WIDTH'(IrIdcode);
  localparam logic [IR_WIDTH-1:0] IrUserW   = IR_WIDTH'(IrUser);

  logic tck_s, tms_s, tdi_s, trst_n_s;

  adam_jtag_sync #(.Stages(SYNC_STAGES), .ResetValue(1'b0)) u_sync_tck (
    .clk(seq_clk), .rst(seq_rst), .d(jtag_tck), .q(tck_s)
  );
  adam_jtag_sync #(.Stages(SYNC_STAGES), .ResetValue(1'b1)) u_sync_tms (
    .clk(seq_clk), .rst(seq_rst), .d(jtag_tms), .q(tms_s)
  );
  adam_jtag_sync #(.Stages(SYNC_STAGES), .ResetValue(1'b0)) u_sync_tdi (
    .clk(seq_clk), .rst(seq_rst), .d(jtag_tdi), .q(tdi_s)
  );
  adam_jtag_sync #(.Stages(SYNC_STAGES), .ResetValue(1'b1)) u_sync_trst (
    .clk(seq_clk), .rst(seq_rst), .d(jtag_trst_n), .q(trst_n_s)
  );

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [31:0]         dr_shift_q, dr_shift_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d;
  logic [31:0]         user_data_q, user_data_d;
  logic                user_valid_q, user_valid_d;
  logic                pause_ack_q;
  logic                tck_prev_q;

  // The edge detector keeps tracking during pause so no stale edge appears on resume.
  logic tck_rise, tck_fall;
  assign tck_rise = tck_s & ~tck_prev_q & ~pause_ack_q;
  assign tck_fall = ~tck_s & tck_prev_q & ~pause_ack_q;

  logic sel_idcode, sel_user, sel_bypass;
  assign sel_idcode = (ir_q == IrIdcodeW);
  assign sel_user   = (ir_q == IrUserW);
  assign sel_bypass = ~sel_idcode & ~sel_user;

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    ir_shift_d   = ir_shift_q;
    dr_shift_d   = dr_shift_q;
    bypass_d     = bypass_q;
    tdo_d        = tdo_q;
    user_data_d  = user_data_q;
    user_valid_d = 1'b0;

    if (!trst_n_s) begin
      state_d = TestLogicReset;
      ir_d    = IrIdcodeW;
    end else begin
      // Capture and shift act on the rising edge, in the state being left.
      if (tck_rise) begin
        state_d = tap_next(state_q, tms_s);
        case (state_q)
          CaptureIr: ir_shift_d = IR_WIDTH'(1);
          ShiftIr:   ir_shift_d = {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
          CaptureDr: begin
            if (sel_idcode)    dr_shift_d = IDCODE;
            else if (sel_user) dr_shift_d = user_data_q;
            else               bypass_d   = 1'b0;
          end
          ShiftDr: begin
            if (sel_bypass) bypass_d   = tdi_s;
            else            dr_shift_d = {tdi_s, dr_shift_q[31:1]};
          end
          default: ;
        endcase
      end

      // TDO changes and updates commit on the falling edge.
      if (tck_fall) begin
        case (state_q)
          ShiftIr: tdo_d = ir_shift_q[0];
          ShiftDr: tdo_d = sel_bypass ? bypass_q : dr_shift_q[0];
          UpdateIr: begin
            tdo_d = 1'b0;
            ir_d  = ir_shift_q;
          end
          UpdateDr: begin
            tdo_d = 1'b0;
            if (sel_user) begin
              user_data_d  = dr_shift_q;
              user_valid_d = 1'b1;
            end
          end
          default: tdo_d = 1'b0;
        endcase
      end

      if (state_q == TestLogicReset) ir_d = IrIdcodeW;
    end
  end

  always_ff @(posedge seq_clk) begin
    if (seq_rst) begin
      state_q      <= TestLogicReset;
      ir_q         <= IrIdcodeW;
      ir_shift_q   <= '0;
      dr_shift_q   <= '0;
      bypass_q     <= 1'b0;
      tdo_q        <= 1'b0;
      user_data_q  <= '0;
      user_valid_q <= 1'b0;
      pause_ack_q  <= 1'b1;
      tck_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      ir_shift_q   <= ir_shift_d;
      dr_shift_q   <= dr_shift_d;
      bypass_q     <= bypass_d;
      tdo_q        <= tdo_d;
      user_data_q  <= user_data_d;
      user_valid_q <= user_valid_d;
      pause_ack_q  <= pause_req;
      tck_prev_q   <= tck_s;
    end
  end

  assign pause_ack  = pause_ack_q;
  assign jtag_tdo   = tdo_q;
  assign user_data  = user_data_q;
  assign user_valid = user_valid_q;

endmodule

// File: tb/tb_adam_jtag_tap.sv
// Directed bench for adam_jtag_tap: drives slow TCK sequences through the
// synchronizers and checks scans, pause, trst and reset behaviour.
module tb_adam_jtag_tap;
  import adam_jtag_tap_pkg::*;

  logic        clk = 1'b0;
  logic        seq_rst;
  logic        pause_req;
  logic        pause_ack;
  logic        jtag_trst_n;
  logic        jtag_tck;
  logic        jtag_tms;
  logic        jtag_tdi;
  logic        jtag_tdo;
  logic [31:0] user_data;
  logic        user_valid;

  int n_vec = 0;
  int n_err = 0;
  int uv_count = 0;

  always #5 clk = ~clk;

  adam_jtag_tap dut (
    .seq_clk    (clk),
    .seq_rst    (seq_rst),
    .pause_req  (pause_req),
    .pause_ack  (pause_ack),
    .jtag_trst_n(jtag_trst_n),
    .jtag_tck   (jtag_tck),
    .jtag_tms   (jtag_tms),
    .jtag_tdi   (jtag_tdi),
    .jtag_tdo   (jtag_tdo),
    .user_data  (user_data),
    .user_valid (user_valid)
  );

  always @(negedge clk) if (user_valid === 1'b1) uv_count++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One TCK period; returns TDO as seen just before the rising edge.
  task automatic tck_pulse(input logic tms, input logic tdi, output logic tdo);
    @(negedge clk);
    jtag_tms = tms;
    jtag_tdi = tdi;
    tdo      = jtag_tdo;
    repeat (2) @(negedge clk);
    jtag_tck = 1'b1;
    repeat (6) @(negedge clk);
    jtag_tck = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic tms_seq(input logic tms);
    logic unused;
    tck_pulse(tms, 1'b0, unused);
  endtask

  // From Run-Test/Idle: full DR scan of n bits, back to Run-Test/Idle.
  task automatic scan_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    logic b;
    dout = '0;
    tms_seq(1'b1);
    tms_seq(1'b0);
    tms_seq(1'b0);
    for (int k = 0; k < n; k++) begin
      tck_pulse(k == n - 1, din[k], b);
      dout[k] = b;
    end
    tms_seq(1'b1);
    tms_seq(1'b0);
  endtask

  // From Run-Test/Idle: full IR scan, back to Run-Test/Idle.
  task automatic scan_ir(input logic [4:0] din, output logic [4:0] dout);
    logic b;
    dout = '0;
    tms_seq(1'b1);
    tms_seq(1'b1);
    tms_seq(1'b0);
    tms_seq(1'b0);
    for (int k = 0; k < 5; k++) begin
      tck_pulse(k == 4, din[k], b);
      dout[k] = b;
    end
    tms_seq(1'b1);
    tms_seq(1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [4:0]  ir_out;
    logic [31:0] pin, pout;
    logic        b;
    int          uv_base;

    seq_rst     = 1'b1;
    pause_req   = 1'b1;
    jtag_trst_n = 1'b1;
    jtag_tck    = 1'b0;
    jtag_tms    = 1'b1;
    jtag_tdi    = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_pause_ack", 32'(pause_ack), 32'd1);
    check_eq("rst_tdo", 32'(jtag_tdo), 32'd0);
    check_eq("rst_user_data", user_data, 32'd0);
    check_eq("rst_user_valid", 32'(user_valid), 32'd0);
    check_eq("rst_ir", 32'(dut.ir_q), 32'h01);
    seq_rst = 1'b0;
    @(negedge clk);
    pause_req = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("unpause_ack", 32'(pause_ack), 32'd0);

    // IDCODE scan after Test-Logic-Reset
    repeat (5) tms_seq(1'b1);
    tms_seq(1'b0);
    check_eq("rti_state", 32'(dut.state_q), 32'(RunTestIdle));
    scan_dr(32'h0, 32, d);
    check_eq("idcode_stream", d, 32'h0000_0001);

    // USER register load and rescan
    scan_ir(5'h10, ir_out);
    check_eq("ir_capture", 32'(ir_out), 32'h01);
    uv_base = uv_count;
    scan_dr(32'hDEAD_BEEF, 32, d);
    check_eq("user_first_out", d, 32'h0);
    check_eq("user_data_load", user_data, 32'hDEAD_BEEF);
    check_eq("user_valid_pulses", 32'(uv_count - uv_base), 32'd1);
    scan_dr(32'hCAFE_F00D, 32, d);
    check_eq("user_rescan", d, 32'hDEAD_BEEF);
    check_eq("user_data_load2", user_data, 32'hCAFE_F00D);
    check_eq("user_valid_pulses2", 32'(uv_count - uv_base), 32'd2);

    // Pause in the middle of Shift-DR
    pin  = 32'h1357_9BDF;
    pout = '0;
    tms_seq(1'b1);
    tms_seq(1'b0);
    tms_seq(1'b0);
    for (int k = 0; k < 12; k++) begin
      tck_pulse(1'b0, pin[k], b);
      pout[k] = b;
    end
    @(negedge clk);
    pause_req = 1'b1;
    check_eq("pause_ack_lat0", 32'(pause_ack), 32'd0);
    @(negedge clk);
    check_eq("pause_ack_lat1", 32'(pause_ack), 32'd1);
    for (int i = 0; i < 10; i++) begin
      jtag_tms = 1'b1;
      jtag_tdi = 1'($urandom_range(1));
      jtag_tck = 1'b1;
      repeat (3) @(negedge clk);
      jtag_tck = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check_eq("pause_tdo_hold", 32'(jtag_tdo), 32'd1);
    check_eq("pause_state_hold", 32'(dut.state_q), 32'(ShiftDr));
    pause_req = 1'b0;
    check_eq("resume_ack_lat0", 32'(pause_ack), 32'd1);
    @(negedge clk);
    check_eq("resume_ack_lat1", 32'(pause_ack), 32'd0);
    for (int k = 12; k < 32; k++) begin
      tck_pulse(k == 31, pin[k], b);
      pout[k] = b;
    end
    tms_seq(1'b1);
    tms_seq(1'b0);
    check_eq("pause_stream_out", pout, 32'hCAFE_F00D);
    check_eq("pause_stream_in", user_data, 32'h1357_9BDF);

    // BYPASS and an undefined opcode behaving as BYPASS
    scan_ir(5'h1F, ir_out);
    scan_dr(32'h0000_00A5, 9, d);
    check_eq("bypass_a5", d, 32'h0000_014A);
    scan_ir(5'h07, ir_out);
    scan_dr(32'h0000_005A, 9, d);
    check_eq("bypass_undef", d, 32'h0000_00B4);

    // trst_n pulse inside Shift-DR
    scan_ir(5'h10, ir_out);
    tms_seq(1'b1);
    tms_seq(1'b0);
    tms_seq(1'b0);
    tms_seq(1'b0);
    tms_seq(1'b0);
    @(negedge clk);
    jtag_trst_n = 1'b0;
    @(negedge clk);
    jtag_trst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("trst_state", 32'(dut.state_q), 32'(TestLogicReset));
    check_eq("trst_ir", 32'(dut.ir_q), 32'h01);
    tms_seq(1'b0);
    scan_dr(32'h0, 32, d);
    check_eq("trst_idcode", d, 32'h0000_0001);

    // seq_rst inside Shift-IR
    tms_seq(1'b1);
    tms_seq(1'b1);
    tms_seq(1'b0);
    tms_seq(1'b0);
    check_eq("shift_ir_tdo", 32'(jtag_tdo), 32'd1);
    @(negedge clk);
    seq_rst = 1'b1;
    @(negedge clk);
    check_eq("srst_pause_ack", 32'(pause_ack), 32'd1);
    check_eq("srst_tdo", 32'(jtag_tdo), 32'd0);
    check_eq("srst_user_data", user_data, 32'd0);
    check_eq("srst_user_valid", 32'(user_valid), 32'd0);
    check_eq("srst_state", 32'(dut.state_q), 32'(TestLogicReset));
    seq_rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("srst_unpause", 32'(pause_ack), 32'd0);
    tms_seq(1'b0);
    scan_dr(32'h0, 32, d);
    check_eq("srst_idcode", d, 32'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adam_jtag_tap.md
ADAM_JTAG_TAP -- requirements
Module: adam_jtag_tap

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h0000_0001, meaning the value shifted out on IDCODE instruction; bit 0 SHALL be 1.
REQ-002 SHALL have parameter IR_WIDTH, default 5, meaning the instruction register width.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth for JTAG inputs.
REQ-004 SHALL have port seq.clk, input, 1 bit: the single system clock; every flop is clocked on its rising edge.
REQ-005 SHALL have port seq.rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port pause.req, input, 1 bit: pause request from the power/pause controller.
REQ-007 SHALL have port pause.ack, output, 1 bit: pause acknowledge; 1 means the block is paused.
REQ-008 SHALL have port jtag.trst_n, input, 1 bit: test reset, active-low, asynchronous from the pin.
REQ-009 SHALL have port jtag.tck, input, 1 bit: test clock, oversampled by seq.clk and never used as a clock.
REQ-010 SHALL have port jtag.tms, input, 1 bit: test mode select.
REQ-011 SHALL have port jtag.tdi, input, 1 bit: test data in.
REQ-012 SHALL have port jtag.tdo, output, 1 bit: test data out.
REQ-013 SHALL have port user_data, output, 32 bits: last value captured by Update-DR under the USER instruction.
REQ-014 SHALL have port user_valid, output, 1 bit: one-cycle pulse when user_data is updated.

Function
REQ-015 tck, tms, tdi and trst_n SHALL each pass through SYNC_STAGES flops; TCK rise/fall SHALL be detected by comparing the synchronized tck with its previous value.
REQ-016 The TAP FSM SHALL implement the 16 IEEE 1149.1 states with standard TMS transitions, advancing exactly one state per detected TCK rise.
REQ-017 Instructions: IDCODE = 5'h01, USER = 5'h10, BYPASS = 5'h1F; every other IR value SHALL select BYPASS.
REQ-018 Capture-IR SHALL load 5'b00001 into the IR shift register; Shift-IR SHALL shift LSB-first from tdi; Update-IR SHALL latch the active IR.
REQ-019 Capture-DR SHALL load the selected DR: IDCODE gives IDCODE, USER gives the current user_data, BYPASS gives 1'b0.
REQ-020 Shift-DR SHALL shift LSB-first on each TCK rise; Update-DR under USER SHALL load user_data and pulse user_valid for one seq.clk cycle.
REQ-021 tdo SHALL update only on a detected TCK fall, to the LSB of the active shift register while in Shift-IR or Shift-DR, otherwise 0.
REQ-022 Synchronized trst_n = 0, or Test-Logic-Reset, SHALL set IR to IDCODE; trst_n has priority over TCK edges in the same cycle.
REQ-023 Pause: pause.ack SHALL follow pause.req with 1 seq.clk cycle latency, in both directions.
REQ-024 While pause.ack = 1, detected TCK edges SHALL be discarded; FSM state, shift registers, IR and tdo SHALL hold; the synchronizers SHALL keep running.
REQ-025 An edge detected in the same cycle that pause.ack rises SHALL be discarded; the first edge after pause.ack falls SHALL be processed normally.
REQ-026 trst_n SHALL be honoured even while paused.

Reset
REQ-027 On seq.rst: FSM = Test-Logic-Reset, IR = IDCODE, shift registers = 0, tdo = 0, user_data = 0, user_valid = 0, pause.ack = 1 (paused), synchronizers = idle values (tck 0, tms 1, trst_n 1).
REQ-028 seq.rst SHALL dominate trst_n, pause.req and any TCK edge in the same cycle.

Structure
REQ-029 Package adam_jtag_tap_pkg SHALL hold the TAP state enum and the IR opcode constants.
REQ-030 One sub-module, adam_jtag_sync (parameterized N-flop synchronizer with reset value), SHALL be instantiated per JTAG input.

Verification
REQ-031 Reset, release pause (req 0), 5 TCK with TMS=1, then TMS=0 to Run-Test/Idle, scan DR 32 bits -> tdo stream = 32'h0000_0001 LSB-first.
REQ-032 Load IR 5'h10, shift DR in 32'hDEAD_BEEF, Update-DR -> user_data = 32'hDEAD_BEEF with a single user_valid pulse; a rescan of DR outputs 32'hDEAD_BEEF.
REQ-033 IR = 5'h1F, shift 8 bits 8'hA5 -> tdo returns 8'hA5 delayed by exactly 1 TCK.
REQ-034 Assert pause.req mid-Shift-DR, toggle TCK 10 times, deassert -> pause.ack 1 cycle after each req change; resume outputs the remaining bits with none lost or duplicated.
REQ-035 Pulse trst_n low in Shift-DR -> FSM in Test-Logic-Reset and IR = 5'h01 within SYNC_STAGES+1 cycles.
REQ-036 Assert seq.rst in Shift-IR -> all outputs at reset values the next cycle, with pause.ack = 1.
